fir_coef_controller: RTL and testbench
======================================

FIR_COEF_CONTROLLER -- requirements
Module: fir_coef_controller

Interface
REQ-001 The block SHALL have parameter FILTER_BITS, default 12, coefficient width.
REQ-002 The block SHALL have parameter FILTER_TAPS, default 64, coefficient count (power of two).
REQ-003 The block SHALL have parameter DATA_BITS, default 17, sample width.
REQ-004 The block SHALL have parameter PIPE_LATENCY, default 8, filter cycles from sample accept to data_out_ready.
REQ-005 The block SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-007 The block SHALL have ports cfg_valid (input, 1), cfg_ready (output, 1), cfg_addr (input, $clog2(FILTER_TAPS)) and cfg_data (input, FILTER_BITS), the coefficient write channel.
REQ-008 The block SHALL have ports commit_req (input, 1), commit_ack (output, 1) and commit_err (output, 1), the bank swap request and its result pulses.
REQ-009 The block SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_data (input, DATA_BITS), the upstream sample stream.
REQ-010 The block SHALL have ports f_data_in_ready (output, 1) and f_data_in (output, DATA_BITS), which drive the filter input.
REQ-011 The block SHALL have port f_data_out_ready, input, 1, the filter output strobe.
REQ-012 The block SHALL have port coef_active, output, FILTER_BITS x FILTER_TAPS, the active coefficient bank fed to the filter.
REQ-013 The block SHALL have port active_bank, output, 1, the index of the active bank.

Function
REQ-014 The block SHALL hold two coefficient banks; one is active and drives coef_active combinationally from the bank register, the other is the shadow bank.
REQ-015 A cfg write SHALL occur on cfg_valid && cfg_ready, writing cfg_data to shadow[cfg_addr] and setting written_mask[cfg_addr]; a rewritten address overwrites the old value.
REQ-016 cfg_ready SHALL be 1 in IDLE and LOAD and 0 in DRAIN and SWAP.
REQ-017 The FSM SHALL have states IDLE (mask empty), LOAD (mask non-empty), DRAIN and SWAP.
REQ-018 Transitions SHALL be: IDLE->LOAD on the first write; LOAD/IDLE->DRAIN on commit_req with a full mask; DRAIN->SWAP when inflight==0; SWAP->IDLE after exactly 1 cycle.
REQ-019 A commit_req while the mask is not full SHALL produce a 1-cycle commit_err pulse and leave the state unchanged.
REQ-020 The full-mask check SHALL include a write accepted in the same cycle as commit_req.
REQ-021 commit_req while in DRAIN or SWAP SHALL be ignored, with no ack and no error.
REQ-022 In SWAP the block SHALL toggle active_bank, clear written_mask and pulse commit_ack for 1 cycle; the new coefficients appear on coef_active on the following cycle.
REQ-023 s_ready SHALL be 1 in IDLE and LOAD and 0 in DRAIN and SWAP.
REQ-024 On s_valid && s_ready the block SHALL register f_data_in <= s_data and f_data_in_ready <= 1, giving 1-cycle latency; f_data_in_ready is otherwise 0 and f_data_in holds its last value.
REQ-025 The inflight counter, $clog2(PIPE_LATENCY+2) bits wide, SHALL increment on f_data_in_ready and decrement on f_data_out_ready; both in the same cycle SHALL leave it unchanged.
REQ-026 An underflow (decrement at 0) SHALL hold the counter at 0.
REQ-027 DRAIN SHALL last at most PIPE_LATENCY+1 cycles with a well-behaved filter, so no sample is ever multiplied by a bank that is partly old and partly new.

Reset
REQ-028 Reset assertion SHALL immediately set: state IDLE, active_bank 0, both banks all-zero, written_mask 0, inflight 0, f_data_in_ready 0, f_data_in 0, commit_ack 0, commit_err 0, s_ready 1, cfg_ready 1.
REQ-029 Reset asserted mid-DRAIN or mid-SWAP SHALL abandon the commit; no commit_ack is issued after reset release.
REQ-030 Reset deassertion SHALL be synchronised externally, and the block SHALL accept traffic on the first clk edge after release.

Structure
REQ-031 Package fir_ctrl_pkg SHALL hold the FSM state enum (IDLE, LOAD, DRAIN, SWAP) and the default constants FILTER_BITS, FILTER_TAPS, DATA_BITS and PIPE_LATENCY.
REQ-032 The inflight counter SHALL be a sub-module named fir_inflight_tracker, with inputs inc and dec and outputs count and zero.
REQ-033 Bank storage and the FSM SHALL stay in fir_coef_controller.

Verification
REQ-034 The bench SHALL cover: reset, then write taps 0..63 with values 1..64, then commit_req -> commit_ack 1 cycle after DRAIN exits, active_bank=1, coef_active[5]=6.
REQ-035 The bench SHALL cover: write taps 0..62 only, then commit_req -> commit_err for 1 cycle, state LOAD, active_bank unchanged, cfg_ready=1.
REQ-036 The bench SHALL cover: 3 samples accepted, then commit_req with a full mask -> s_ready=0 until 3 f_data_out_ready strobes are seen, then SWAP, then s_ready=1.
REQ-037 The bench SHALL cover: tap 63 written in the same cycle as commit_req with taps 0..62 already written -> commit accepted, no commit_err.
REQ-038 The bench SHALL cover: rst asserted during DRAIN -> all outputs at their reset values immediately, and no commit_ack after release.
REQ-039 The bench SHALL cover: continuous s_valid=1 stream with no commit -> f_data_in_ready every cycle, f_data_in = s_data delayed 1 cycle, inflight saturates at PIPE_LATENCY.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared types and default sizing for the FIR coefficient controller.
// Imported by the controller and the inflight tracker.
package fir_ctrl_pkg;

  localparam int FILTER_BITS  = 12;
  localparam int FILTER_TAPS  = 64;
  localparam int DATA_BITS    = 17;
  localparam int PIPE_LATENCY = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    SWAP
  } state_t;

endpackage

// File: rtl/fir_inflight_tracker.sv
// Counts samples inside the filter pipeline.
// Saturates at both ends so a misbehaving filter cannot wrap it.
module fir_inflight_tracker #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      unique case ({inc, dec})
        2'b10:   if (count != '1) count <= count + 1'b1;
        2'b01:   if (count != '0) count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_coef_controller.sv
// Double-buffered FIR coefficient banks with a drain-then-swap commit,
// plus the registered sample path into the filter.
module fir_coef_controller #(
  parameter int FILTER_BITS  = fir_ctrl_pkg::FILTER_BITS,
  parameter int FILTER_TAPS  = fir_ctrl_pkg::FILTER_TAPS,
  parameter int DATA_BITS    = fir_ctrl_pkg::DATA_BITS,
  parameter int PIPE_LATENCY = fir_ctrl_pkg::PIPE_LATENCY
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [$clog2(FILTER_TAPS)-1:0]   cfg_addr,
  input  logic [FILTER_BITS-1:0]           cfg_data,
  input  logic                             commit_req,
  output logic                             commit_ack,
  output logic                             commit_err,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DATA_BITS-1:0]             s_data,
  output logic                             f_data_in_ready,
  output logic [DATA_BITS-1:0]             f_data_in,
  input  logic                             f_data_out_ready,
  output logic [FILTER_BITS*FILTER_TAPS-1:0] coef_active,
  output logic                             active_bank
);

  import fir_ctrl_pkg::*;

  localparam int CW = $clog2(PIPE_LATENCY + 2);

  state_t                 state;
  logic [FILTER_BITS-1:0] bank0 [FILTER_TAPS];
  logic [FILTER_BITS-1:0] bank1 [FILTER_TAPS];
  logic [FILTER_TAPS-1:0] written_mask;
  logic [FILTER_TAPS-1:0] wr_hot;
  logic [FILTER_TAPS-1:0] mask_next;
  logic [CW-1:0]          inflight_count;
  logic                   inflight_zero;
  logic                   cfg_we;
  logic                   s_fire;
  logic                   mask_full;
  logic                   drained;

  assign cfg_ready = (state == IDLE) || (state == LOAD);
  assign s_ready   = cfg_ready;
  assign cfg_we    = cfg_valid && cfg_ready;
  assign s_fire    = s_valid && s_ready;
  assign wr_hot    = cfg_we ? (FILTER_TAPS'(1) << cfg_addr) : '0;
  assign mask_next = written_mask | wr_hot;
  assign mask_full = &mask_next;
  // A sample registered last cycle is not yet counted; wait for it too.
  assign drained   = inflight_zero && !f_data_in_ready;

  for (genvar i = 0; i < FILTER_TAPS; i++) begin : g_coef
    assign coef_active[i*FILTER_BITS +: FILTER_BITS] =
      active_bank ? bank1[i] : bank0[i];
  end

  fir_inflight_tracker #(
    .W(CW)
  ) u_inflight (
    .clk  (clk),
    .rst  (rst),
    .inc  (f_data_in_ready),
    .dec  (f_data_out_ready),
    .count(inflight_count),
    .zero (inflight_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FILTER_TAPS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (cfg_we) begin
      if (active_bank) bank0[cfg_addr] <= cfg_data;
      else             bank1[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      active_bank  <= 1'b0;
      written_mask <= '0;
      commit_ack   <= 1'b0;
      commit_err   <= 1'b0;
    end else begin
      commit_ack <= 1'b0;
      commit_err <= 1'b0;
      unique case (state)
        IDLE, LOAD: begin
          written_mask <= mask_next;
          if (commit_req && mask_full) begin
            state <= DRAIN;
          end else begin
            commit_err <= commit_req;
            if (|mask_next) state <= LOAD;
          end
        end
        DRAIN: if (drained) state <= SWAP;
        SWAP: begin
          state        <= IDLE;
          active_bank  <= ~active_bank;
          written_mask <= '0;
          commit_ack   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_data_in_ready <= 1'b0;
      f_data_in       <= '0;
    end else begin
      f_data_in_ready <= s_fire;
      if (s_fire) f_data_in <= s_data;
    end
  end

endmodule

// File: tb/tb_fir_coef_controller.sv
// Directed bench for fir_coef_controller with a simple fixed-latency
// filter model that can be swapped for manual output strobes.
module tb_fir_coef_controller;

  import fir_ctrl_pkg::*;

  localparam int FB = 12;
  localparam int FT = 64;
  localparam int DB = 17;
  localparam int PL = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [5:0]      cfg_addr;
  logic [FB-1:0]   cfg_data;
  logic            commit_req;
  logic            commit_ack;
  logic            commit_err;
  logic            s_valid;
  logic            s_ready;
  logic [DB-1:0]   s_data;
  logic            f_data_in_ready;
  logic [DB-1:0]   f_data_in;
  logic            f_data_out_ready;
  logic [FB*FT-1:0] coef_active;
  logic            active_bank;

  logic            auto_filter;
  logic            man_out;
  logic [PL-1:0]   pipe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_coef_controller dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .commit_req      (commit_req),
    .commit_ack      (commit_ack),
    .commit_err      (commit_err),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .f_data_in_ready (f_data_in_ready),
    .f_data_in       (f_data_in),
    .f_data_out_ready(f_data_out_ready),
    .coef_active     (coef_active),
    .active_bank     (active_bank)
  );

  // Well-behaved filter: output strobe PL cycles after the sample accept.
  always @(posedge clk or negedge rst) begin
    if (!rst) pipe <= '0;
    else      pipe <= {pipe[PL-2:0], f_data_in_ready};
  end
  assign f_data_out_ready = auto_filter ? pipe[PL-1] : man_out;

  function automatic logic [31:0] tap(input int i);
    return 32'(coef_active[i*FB +: FB]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cfg_valid  = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    commit_req = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    man_out    = 1'b0;
  endtask

  task automatic write_taps(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_addr  = 6'(i);
      cfg_data  = FB'(base + i);
      step();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bank"},  32'(active_bank), 32'd0);
    chk({tag, "_sr"},    32'(s_ready), 32'd1);
    chk({tag, "_cr"},    32'(cfg_ready), 32'd1);
    chk({tag, "_ack"},   32'(commit_ack), 32'd0);
    chk({tag, "_err"},   32'(commit_err), 32'd0);
    chk({tag, "_fdir"},  32'(f_data_in_ready), 32'd0);
    chk({tag, "_fdi"},   32'(f_data_in), 32'd0);
    chk({tag, "_coef"},  32'(coef_active == '0), 32'd1);
    chk({tag, "_infl"},  32'(dut.u_inflight.count), 32'd0);
    chk({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    auto_filter = 1'b0;
    idle_inputs();
    rst = 1'b0;
    #2;
    check_reset_outputs("rst0");
    step();
    step();
    rst = 1'b1;

    // Full bank load and commit
    write_taps(64, 1);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    chk("c1_drain_sr", 32'(s_ready), 32'd0);
    chk("c1_drain_cr", 32'(cfg_ready), 32'd0);
    chk("c1_noerr", 32'(commit_err), 32'd0);
    step();
    chk("c1_swap_state", 32'(dut.state), 32'(SWAP));
    chk("c1_swap_noack", 32'(commit_ack), 32'd0);
    chk("c1_swap_bank", 32'(active_bank), 32'd0);
    step();
    chk("c1_ack", 32'(commit_ack), 32'd1);
    chk("c1_bank", 32'(active_bank), 32'd1);
    chk("c1_tap5", tap(5), 32'd6);
    chk("c1_tap63", tap(63), 32'd64);
    step();
    chk("c1_ack_pulse", 32'(commit_ack), 32'd0);
    chk("c1_sr_back", 32'(s_ready), 32'd1);

    // Incomplete mask is rejected
    write_taps(63, 100);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    chk("c2_err", 32'(commit_err), 32'd1);
    chk("c2_state", 32'(dut.state), 32'(LOAD));
    chk("c2_bank", 32'(active_bank), 32'd1);
    chk("c2_cr", 32'(cfg_ready), 32'd1);
    step();
    chk("c2_err_pulse", 32'(commit_err), 32'd0);

    // Last tap written alongside the commit request
    cfg_valid  = 1'b1;
    cfg_addr   = 6'd63;
    cfg_data   = 12'd163;
    commit_req = 1'b1;
    step();
    idle_inputs();
    chk("c4_noerr", 32'(commit_err), 32'd0);
    chk("c4_state", 32'(dut.state), 32'(DRAIN));
    step();
    step();
    chk("c4_ack", 32'(commit_ack), 32'd1);
    chk("c4_bank", 32'(active_bank), 32'd0);
    chk("c4_tap63", tap(63), 32'd163);
    chk("c4_tap0", tap(0), 32'd100);
    step();

    // Drain waits for three in-flight samples
    write_taps(64, 200);
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data  = DB'(500 + k);
      step();
      chk("c3_fdir", 32'(f_data_in_ready), 32'd1);
      chk("c3_fdi", 32'(f_data_in), 32'(500 + k));
    end
    s_valid    = 1'b0;
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    chk("c3_drain_sr", 32'(s_ready), 32'd0);
    chk("c3_infl3", 32'(dut.u_inflight.count), 32'd3);
    step();
    chk("c3_hold_sr", 32'(s_ready), 32'd0);
    chk("c3_hold_state", 32'(dut.state), 32'(DRAIN));
    for (int k = 0; k < 3; k++) begin
      man_out = 1'b1;
      step();
      man_out = 1'b0;
      chk("c3_strobe_sr", 32'(s_ready), 32'd0);
      chk("c3_strobe_ack", 32'(commit_ack), 32'd0);
      chk("c3_strobe_infl", 32'(dut.u_inflight.count), 32'(2 - k));
    end
    step();
    chk("c3_swap_state", 32'(dut.state), 32'(SWAP));
    chk("c3_swap_sr", 32'(s_ready), 32'd0);
    step();
    chk("c3_ack", 32'(commit_ack), 32'd1);
    chk("c3_sr", 32'(s_ready), 32'd1);
    chk("c3_bank", 32'(active_bank), 32'd1);
    chk("c3_tap10", tap(10), 32'd210);
    step();

    // Reset in the middle of a drain
    write_taps(64, 300);
    s_valid = 1'b1;
    s_data  = DB'(77);
    step();
    s_valid    = 1'b0;
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    chk("c5_in_drain", 32'(dut.state), 32'(DRAIN));
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("c5_rst");
    #2;
    rst = 1'b1;
    cfg_valid = 1'b1;
    cfg_addr  = 6'd7;
    cfg_data  = 12'd55;
    step();
    cfg_valid = 1'b0;
    chk("c5_first_edge", 32'(dut.state), 32'(LOAD));
    chk("c5_noack0", 32'(commit_ack), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("c5_noack", 32'(commit_ack), 32'd0);
    end
    chk("c5_bank", 32'(active_bank), 32'd0);

    // Continuous stream through the fixed-latency filter
    auto_filter = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s_valid = 1'b1;
      s_data  = DB'(1000 + 3 * k);
      step();
      chk("c6_fdir", 32'(f_data_in_ready), 32'd1);
      chk("c6_fdi", 32'(f_data_in), 32'(1000 + 3 * k));
      chk("c6_infl", 32'(dut.u_inflight.count), 32'((k < PL) ? k : PL));
    end
    s_valid = 1'b0;
    step();
    chk("c6_idle_fdir", 32'(f_data_in_ready), 32'd0);
    chk("c6_hold_fdi", 32'(f_data_in), 32'(1000 + 3 * 19));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
